// File: rtl/lzc_pkg.sv
// Shared constants and FSM encoding for the leading-zero denormaliser.
package lzc_pkg;
  localparam int LZC_N  = 32;
  localparam int LZC_CW = $clog2(LZC_N) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } lzc_denorm_state_t;
endpackage

// File: rtl/lzc_denorm_if.sv
// Upstream word/count and downstream result channels, each with a valid/ready pair.
interface lzc_denorm_if import lzc_pkg::*; #(
  parameter int N = LZC_N
);
  localparam int CW = $clog2(N) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [CW-1:0] in_count;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_err;

  modport master (
    output in_valid, in_data, in_count, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, in_count, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/lzc_shift_stage.sv
// Conditional logical right shift by 2^K; combinational, no handshake.
module lzc_shift_stage #(
  parameter int N = 32,
  parameter int K = 0
) (
  input  logic         en,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);
  generate
    if ((1 << K) >= N) begin : g_clear
      assign dout = en ? '0 : din;
    end else begin : g_shift
      assign dout = en ? (din >> (1 << K)) : din;
    end
  endgenerate
endmodule

// File: rtl/lzc_denorm.sv
// Restores norm >> count with one log-shift stage per clock; out_valid rises CW clocks after accept.
// Single word in flight; in_ready low until the result is taken. LZC_DENORM_CHECK_EN adds out_err.
module lzc_denorm import lzc_pkg::*; #(
  parameter int N = LZC_N
) (
  input logic         clk,
  input logic         rst_n,
  lzc_denorm_if.slave bus
);
  localparam int CW = $clog2(N) + 1;
  localparam int SW = $clog2(CW);

  lzc_denorm_state_t state, nxt;
  logic [N-1:0]  sreg;
  logic [N-1:0]  shifted;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_sat;
  logic [SW-1:0] stage;
  logic [N-1:0]  stg_out [CW];
  logic          accept;

  for (genvar k = 0; k < CW; k++) begin : g_stage
    lzc_shift_stage #(.N(N), .K(k)) u_stage (
      .en   (cnt[k]),
      .din  (sreg),
      .dout (stg_out[k])
    );
  end

  always_comb begin
    shifted = sreg;
    for (int k = 0; k < CW; k++) begin
      if (stage == SW'(k)) shifted = stg_out[k];
    end
  end

  assign cnt_sat = (bus.in_count > CW'(N)) ? CW'(N) : bus.in_count;
  assign accept  = bus.in_valid && (state == IDLE);

  always_comb begin
    nxt           = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) nxt = SHIFT;
      end
      SHIFT: begin
        if (stage == '0) nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      stage <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= bus.in_data;
            cnt   <= cnt_sat;
            stage <= SW'(CW - 1);
          end
        end
        SHIFT: begin
          sreg <= shifted;
          if (stage != '0) stage <= stage - SW'(1);
        end
        default: ;
      endcase
    end
  end

  // The shift register is the result; it only moves in IDLE-accept and SHIFT.
  assign bus.out_data = sreg;

`ifdef LZC_DENORM_CHECK_EN
  logic err_q;
  logic err_d;

  assign err_d = (bus.in_count > CW'(N))
              || ((bus.in_count < CW'(N)) && !bus.in_data[N-1])
              || ((bus.in_count == CW'(N)) && (|bus.in_data));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= err_d;
    end
  end

  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_lzc_denorm.sv
// Scoreboard bench for lzc_denorm: directed vectors, backpressure, mid-op reset, random sweep.
module tb_lzc_denorm;
  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

`ifdef LZC_DENORM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  bit   rdy_mode;
  exp_t q[$];

  lzc_denorm_if #(.N(32)) bus ();

  lzc_denorm #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic int clz(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    return n;
  endfunction

  // Monitor: every completed output handshake pops and compares one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got 0x%08h with empty scoreboard", bus.out_data);
        end else begin
          e = q.pop_front();
          check("out_data", bus.out_data, e.d);
          check("out_err", {31'd0, bus.out_err}, {31'd0, e.e});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [31:0] d, input logic [5:0] c,
                      input logic [31:0] ed, input logic ee, input bit track);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_count = c;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%0d expected 1", bus.in_ready);
    end else if (track) begin
      q.push_back('{ed, ee});
    end
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    bus.in_count = c + 6'd7;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !bus.in_ready || bus.out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    logic [31:0] orig;
    int lz;
    total    = 0;
    bad      = 0;
    rdy_mode = 1'b0;
    rst_n    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_count  = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_err", {31'd0, bus.out_err}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Latency of the first word
    send(32'h8000_0000, 6'd31, 32'h0000_0001, 1'b0, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 50);
    check("latency", 32'(n - 1), 32'd6);
    drain();

    send(32'hC000_1234, 6'd0,  32'hC000_1234, 1'b0, 1'b1);
    send(32'h0000_0000, 6'd32, 32'h0000_0000, 1'b0, 1'b1);
    send(32'h8000_0000, 6'd40, 32'h0000_0000, CHK,  1'b1);
    send(32'h4000_0000, 6'd3,  32'h0800_0000, CHK,  1'b1);
    send(32'h8000_0001, 6'd1,  32'h4000_0000, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 6'd63, 32'h0000_0000, CHK,  1'b1);
    send(32'h0000_0010, 6'd32, 32'h0000_0000, CHK,  1'b1);
    send(32'hA5A5_0000, 6'd8,  32'h00A5_A500, 1'b0, 1'b1);
    drain();

    // Backpressure: result held while out_ready is low, next word waits for the handshake
    bus.out_ready = 1'b0;
    send(32'hFFFF_FFFF, 6'd16, 32'h0000_FFFF, 1'b0, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h8000_0001;
    bus.in_count = 6'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_out_data", bus.out_data, 32'h0000_FFFF);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
    q.push_back('{32'h4000_0000, 1'b0});
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("second_accepted", {31'd0, bus.in_ready}, 32'd0);
    drain();

    // Reset during SHIFT: the word must vanish
    send(32'h8765_4321, 6'd0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_out_data", bus.out_data, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_quiet", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #2;

    // Random sweep with random downstream readiness
    rdy_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      orig = $urandom;
      orig = orig >> $urandom_range(0, 32);
      lz   = clz(orig);
      send(orig << lz, 6'(lz), orig, 1'b0, 1'b1);
    end
    rdy_mode = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
